pipe_elastic_buf: RTL and testbench
===================================

// Module: pipe_elastic_buf
// PURPOSE
//   Parametrised elastic buffer between two pipeline stages (e.g. fetch->decode, decode->execute).
//   Carries any pipes:: stage payload as a flat WIDTH-bit vector and stores up to DEPTH entries in order.
//   Uses a valid/ready handshake on both sides and has a synchronous flush for branch/exception squash.
//   Replaces the plain per-stage valid register: it adds back-pressure, buffering and an optional same-cycle bypass.
// PARAMETERS
//   WIDTH     64   payload width in bits (set to $bits(<stage>_data_t))
//   DEPTH     2    number of storage entries, >=1, need not be a power of two
//   PASSTHRU  0    1: when the buffer is empty, in_data reaches out_data in the same cycle; 0: minimum latency is 1 cycle
//   CW        $clog2(DEPTH+1)  width of the occupancy count (derived; do not override)
// PORTS
//   clk        in   1       clock, all state updates on the rising edge
//   reset      in   1       asynchronous, active-high reset
//   flush      in   1       synchronous squash of all held entries
//   in_valid   in   1       upstream stage has a payload
//   in_ready   out  1       buffer accepts a payload this cycle
//   in_data    in   WIDTH   upstream payload
//   out_valid  out  1       out_data holds a valid payload
//   out_ready  in   1       downstream stage consumes the payload this cycle
//   out_data   out  WIDTH   oldest payload (or the bypassed in_data)
//   count      out  CW      number of stored entries, 0..DEPTH
// BEHAVIOUR
//   - State: mem[DEPTH], rd_ptr, wr_ptr (each 0..DEPTH-1), count. mem is not reset.
//   - Reset (asynchronous, effective immediately): count=0, rd_ptr=wr_ptr=0, out_valid=0.
//     in_ready is forced to 0 while reset is high and becomes 1 in the first cycle after reset falls.
//   - in_ready = !reset && !flush && (count != DEPTH). It depends only on registered state, so there is
//     no combinational path from out_ready to in_ready.
//   - PASSTHRU=0: out_valid = (count != 0) && !flush; out_data = mem[rd_ptr].
//   - PASSTHRU=1: out_valid = ((count != 0) || in_valid) && !flush;
//     out_data = (count != 0) ? mem[rd_ptr] : in_data.
//   - push = in_valid && in_ready; pop = out_valid && out_ready.
//   - Bypass hit (PASSTHRU=1, count==0, push, pop): the payload leaves the same cycle and is not written;
//     count stays 0.
//   - Otherwise, on push: mem[wr_ptr] <= in_data and wr_ptr advances. On pop: rd_ptr advances.
//   - Pointer advance: (ptr == DEPTH-1) ? 0 : ptr+1.
//   - count_next = count + push - pop (a bypass hit counts as neither).
//     A push and a pop in the same cycle leave count unchanged.
//   - Full (count==DEPTH): in_ready=0, so the upstream stage stalls. A pop in this cycle lowers count,
//     and in_ready rises on the next cycle.
//   - Empty (count==0, PASSTHRU=0): out_valid=0, and a push is visible at the output on the next cycle.
//   - flush has highest priority over push and pop.
//     In the flush cycle, in_ready=0 and out_valid=0, so no handshake completes.
//     Next edge: count=0, rd_ptr=wr_ptr=0.
//     The cycle after flush behaves as after reset: in_ready=1 and out_valid=0, unless a bypass fires.
//   - Ordering: payloads leave in exactly the order they were accepted, with no loss or duplication.
//   - out_data is don't-care when out_valid=0; consumers qualify it with out_valid.
//   - Latency: PASSTHRU=0 gives 1 cycle when empty. PASSTHRU=1 gives 0 cycles when empty.
//     Otherwise latency is occupancy-dependent.
// TESTING
//   1 Reset mid-stream: DEPTH=4, count=2, assert reset asynchronously.
//     -> out_valid=0 and count=0 before the next edge; in_ready=0 while reset is high and 1 after it falls.
//   2 Fill/drain: DEPTH=4, out_ready=0, push 0x11,0x22,0x33,0x44.
//     -> count=4 and in_ready=0; then out_ready=1 gives 0x11,0x22,0x33,0x44 on 4 consecutive cycles, ending at count=0.
//   3 Wrap: DEPTH=3, 20 payloads 1..20 with in_valid always 1 and out_ready toggling 1,0,1,0.
//     -> output sequence is exactly 1..20 and count never exceeds 3.
//   4 Simultaneous: count=2 with push and pop in the same cycle.
//     -> count stays 2, and the popped payload is the oldest.
//   5 Flush: count=3 with in_valid=1 and flush=1 for one cycle.
//     -> no handshake in that cycle; next cycle count=0 and out_valid=0; the next pushed 0xAB is the first payload out.
//   6 PASSTHRU=1: empty, in_valid=1 with in_data=0x5A and out_ready=1.
//     -> out_valid=1 and out_data=0x5A in the same cycle, count stays 0.
//     Repeat with out_ready=0. -> count=1 next cycle and 0x5A is held.

Source files
------------

// File: rtl/pipe_elastic_buf.sv
// Elastic buffer between two pipeline stages: DEPTH-entry in-order store with
// valid/ready on both sides, synchronous flush and optional empty-buffer bypass.
module pipe_elastic_buf #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 2,
  parameter bit          PASSTHRU = 1'b0,
  parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             push_st;
  logic             pop_st;

  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign in_ready = !reset && !flush && (count != FULL);

  // out_valid also gated by reset so a bypass-mode pop can never fire without a push
  always_comb begin
    out_valid = 1'b0;
    out_data  = mem[rd_ptr];
    if (PASSTHRU) begin
      out_valid = (!empty || in_valid) && !flush && !reset;
      out_data  = !empty ? mem[rd_ptr] : in_data;
    end else begin
      out_valid = !empty && !flush && !reset;
    end
  end

  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign bypass  = PASSTHRU && empty && push && pop;
  assign push_st = push && !bypass;
  assign pop_st  = pop && !bypass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_st) wr_ptr <= adv(wr_ptr);
      if (pop_st)  rd_ptr <= adv(rd_ptr);
      if (push_st && !pop_st)      count <= count + 1'b1;
      else if (!push_st && pop_st) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_st) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_elastic_buf.sv
// Directed bench for pipe_elastic_buf: three instances cover DEPTH=4, DEPTH=3
// and a DEPTH=2 bypass configuration sharing one clock and reset.
module tb_pipe_elastic_buf;

  logic clk = 1'b0;
  logic reset;
  int unsigned vec  = 0;
  int unsigned errs = 0;

  always #5 clk = ~clk;

  // instance a: DEPTH=4, no bypass
  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_count;
  // instance b: DEPTH=3, no bypass
  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_count;
  // instance c: DEPTH=2, bypass
  logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data, c_out_data;
  logic [1:0] c_count;

  pipe_elastic_buf #(.WIDTH(8), .DEPTH(4), .PASSTHRU(1'b0)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count));

  pipe_elastic_buf #(.WIDTH(8), .DEPTH(3), .PASSTHRU(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count));

  pipe_elastic_buf #(.WIDTH(8), .DEPTH(2), .PASSTHRU(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .count(c_count));

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    #1;
    vec++;
    if (a_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL push_a_ready data=%0h got=%b exp=1", d, a_in_ready);
    end
    next_cycle();
    a_in_valid = 1'b0;
  endtask

  task automatic pop_a(input logic [7:0] exp, input string tag);
    a_out_ready = 1'b1;
    #1;
    vec++;
    if (a_out_valid !== 1'b1 || a_out_data !== exp) begin
      errs++;
      $display("FAIL %s valid=%b data=%0h exp valid=1 data=%0h", tag, a_out_valid, a_out_data, exp);
    end
    next_cycle();
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    vec++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_count !== 3'd0) begin
      errs++;
      $display("FAIL reset_state in_ready=%b out_valid=%b count=%0d exp 0/0/0", a_in_ready, a_out_valid, a_count);
    end
    #12 reset = 1'b0;
    #1;
    vec++;
    if (a_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_release in_ready a=%b c=%b exp 1", a_in_ready, c_in_ready);
    end
  endtask

  task automatic test_fill_drain;
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    next_cycle();
    a_out_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) push_a(vals[i]);
    #1;
    vec++;
    if (a_count !== 3'd4 || a_in_ready !== 1'b0) begin
      errs++;
      $display("FAIL full count=%0d in_ready=%b exp 4/0", a_count, a_in_ready);
    end
    a_out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      vec++;
      if (a_out_valid !== 1'b1 || a_out_data !== vals[i]) begin
        errs++;
        $display("FAIL drain[%0d] valid=%b data=%0h exp 1/%0h", i, a_out_valid, a_out_data, vals[i]);
      end
      next_cycle();
    end
    a_out_ready = 1'b0;
    #1;
    vec++;
    if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin
      errs++;
      $display("FAIL drained count=%0d out_valid=%b exp 0/0", a_count, a_out_valid);
    end
  endtask

  task automatic test_simultaneous;
    next_cycle();
    push_a(8'h01);
    push_a(8'h02);
    a_in_valid  = 1'b1;
    a_in_data   = 8'h03;
    a_out_ready = 1'b1;
    #1;
    vec++;
    if (a_out_data !== 8'h01 || a_in_ready !== 1'b1 || a_count !== 3'd2) begin
      errs++;
      $display("FAIL simul_pre data=%0h in_ready=%b count=%0d exp 01/1/2", a_out_data, a_in_ready, a_count);
    end
    next_cycle();
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    #1;
    vec++;
    if (a_count !== 3'd2) begin
      errs++;
      $display("FAIL simul_count got=%0d exp 2", a_count);
    end
    pop_a(8'h02, "simul_pop1");
    pop_a(8'h03, "simul_pop2");
  endtask

  task automatic test_flush;
    next_cycle();
    push_a(8'h31);
    push_a(8'h32);
    push_a(8'h33);
    a_in_valid  = 1'b1;
    a_in_data   = 8'h99;
    a_out_ready = 1'b1;
    a_flush     = 1'b1;
    #1;
    vec++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_count !== 3'd3) begin
      errs++;
      $display("FAIL flush_cycle in_ready=%b out_valid=%b count=%0d exp 0/0/3", a_in_ready, a_out_valid, a_count);
    end
    next_cycle();
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    #1;
    vec++;
    if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL flush_after count=%0d out_valid=%b in_ready=%b exp 0/0/1", a_count, a_out_valid, a_in_ready);
    end
    push_a(8'hAB);
    pop_a(8'hAB, "flush_first_out");
    #1;
    vec++;
    if (a_count !== 3'd0) begin
      errs++;
      $display("FAIL flush_end count=%0d exp 0", a_count);
    end
  endtask

  task automatic test_wrap;
    int unsigned next_in  = 1;
    int unsigned next_out = 1;
    int unsigned cyc      = 0;
    next_cycle();
    while (next_out <= 20 && cyc < 200) begin
      b_in_valid  = (next_in <= 20);
      b_in_data   = 8'(next_in);
      b_out_ready = (cyc % 2 == 0);
      #1;
      vec++;
      if (b_count > 2'd3) begin
        errs++;
        $display("FAIL wrap_count cyc=%0d got=%0d exp<=3", cyc, b_count);
      end
      if (b_out_valid && b_out_ready) begin
        vec++;
        if (b_out_data !== 8'(next_out)) begin
          errs++;
          $display("FAIL wrap_data got=%0d exp=%0d", b_out_data, next_out);
        end
        next_out++;
      end
      if (b_in_valid && b_in_ready) next_in++;
      next_cycle();
      cyc++;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    vec++;
    if (next_out != 21) begin
      errs++;
      $display("FAIL wrap_timeout outputs=%0d exp=20", next_out - 1);
    end
  endtask

  task automatic test_passthru;
    next_cycle();
    c_in_valid  = 1'b1;
    c_in_data   = 8'h5A;
    c_out_ready = 1'b1;
    #1;
    vec++;
    if (c_out_valid !== 1'b1 || c_out_data !== 8'h5A || c_count !== 2'd0) begin
      errs++;
      $display("FAIL bypass_same valid=%b data=%0h count=%0d exp 1/5a/0", c_out_valid, c_out_data, c_count);
    end
    next_cycle();
    c_in_valid = 1'b0;
    #1;
    vec++;
    if (c_count !== 2'd0 || c_out_valid !== 1'b0) begin
      errs++;
      $display("FAIL bypass_after count=%0d valid=%b exp 0/0", c_count, c_out_valid);
    end
    c_in_valid  = 1'b1;
    c_in_data   = 8'h5A;
    c_out_ready = 1'b0;
    next_cycle();
    c_in_valid = 1'b0;
    c_in_data  = 8'h00;
    #1;
    vec++;
    if (c_count !== 2'd1 || c_out_valid !== 1'b1 || c_out_data !== 8'h5A) begin
      errs++;
      $display("FAIL bypass_hold count=%0d valid=%b data=%0h exp 1/1/5a", c_count, c_out_valid, c_out_data);
    end
    c_out_ready = 1'b1;
    next_cycle();
    c_out_ready = 1'b0;
    #1;
    vec++;
    if (c_count !== 2'd0) begin
      errs++;
      $display("FAIL bypass_drain count=%0d exp 0", c_count);
    end
  endtask

  task automatic test_reset_mid;
    next_cycle();
    push_a(8'h71);
    push_a(8'h72);
    #1;
    vec++;
    if (a_count !== 3'd2 || a_out_valid !== 1'b1) begin
      errs++;
      $display("FAIL rst_mid_pre count=%0d valid=%b exp 2/1", a_count, a_out_valid);
    end
    #1 reset = 1'b1;
    #1;
    vec++;
    if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_async count=%0d valid=%b in_ready=%b exp 0/0/0", a_count, a_out_valid, a_in_ready);
    end
    @(posedge clk);
    #3;
    vec++;
    if (a_in_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_held in_ready=%b exp 0", a_in_ready);
    end
    reset = 1'b0;
    #1;
    vec++;
    if (a_in_ready !== 1'b1 || a_count !== 3'd0 || a_out_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_release in_ready=%b count=%0d valid=%b exp 1/0/0", a_in_ready, a_count, a_out_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_flush();
    test_wrap();
    test_passthru();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
